// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for nano_rv32i.
// Drives datapath strobes from the latched opcode and traps on illegal opcodes or memory timeouts.
module ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic [6:0]  opcode_i,
    input  logic        branch_taken_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    output logic        imem_req_o,
    output logic        ir_write_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        reg_write_o,
    output logic [1:0]  wb_sel_o,
    output logic        pc_write_o,
    output logic [1:0]  pc_sel_o,
    output logic [2:0]  state_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic [31:0] instret_o
);
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd7
    } state_t;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    state_t      r_state, w_next;
    logic [6:0]  r_opcode;
    logic        r_taken, r_pend, r_illegal, r_timeout;
    logic [7:0]  r_cnt, w_cnt;
    logic [31:0] r_instret;
    logic        w_wait, w_limit, w_legal, w_mem_op;
    assign w_legal  = opcode_i inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                       OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    assign w_mem_op = (r_opcode == OP_LOAD) || (r_opcode == OP_STORE);
    // A zero limit disables the timeout entirely.
    assign w_limit  = (MEM_TIMEOUT != 0) && (r_cnt == 8'(MEM_TIMEOUT - 1));
    always_comb begin
        w_next      = r_state;
        imem_req_o  = 1'b0;
        ir_write_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        reg_write_o = 1'b0;
        wb_sel_o    = 2'd0;
        pc_write_o  = 1'b0;
        pc_sel_o    = 2'd0;
        case (r_state)
            S_FETCH: begin
                imem_req_o = run_i | r_pend;
                ir_write_o = imem_req_o & imem_ack_i;
                w_next     = ir_write_o ? S_DECODE : (imem_req_o && w_limit) ? S_TRAP : S_FETCH;
            end
            S_DECODE:  w_next = w_legal ? S_EXECUTE : S_TRAP;
            S_EXECUTE: w_next = w_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = r_opcode == OP_STORE;
                w_next     = dmem_ack_i ? S_WB : w_limit ? S_TRAP : S_MEM;
            end
            S_WB: begin
                pc_write_o  = 1'b1;
                reg_write_o = !((r_opcode == OP_STORE) || (r_opcode == OP_BRANCH));
                wb_sel_o    = (r_opcode == OP_LOAD) ? 2'd1 :
                              ((r_opcode == OP_JAL) || (r_opcode == OP_JALR)) ? 2'd2 : 2'd0;
                pc_sel_o    = ((r_opcode == OP_JAL) || ((r_opcode == OP_BRANCH) && r_taken)) ? 2'd1 :
                              (r_opcode == OP_JALR) ? 2'd2 : 2'd0;
                w_next      = S_FETCH;
            end
            default: w_next = S_TRAP;
        endcase
        w_wait = (imem_req_o & ~imem_ack_i) | (dmem_req_o & ~dmem_ack_i);
        // Only FETCH and MEM keep the count; every other state zeroes it before re-entry.
        w_cnt  = ((r_state == S_FETCH) || (r_state == S_MEM)) ? r_cnt + {7'd0, w_wait} : 8'd0;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_FETCH;
            r_opcode  <= 7'd0;
            r_taken   <= 1'b0;
            r_pend    <= 1'b0;
            r_cnt     <= 8'd0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            r_state   <= w_next;
            r_pend    <= imem_req_o & ~imem_ack_i;
            r_cnt     <= w_cnt;
            r_illegal <= r_illegal | ((r_state == S_DECODE) && !w_legal);
            r_timeout <= r_timeout | (w_wait && w_limit);
            if (r_state == S_DECODE) r_opcode <= opcode_i;
            if (r_state == S_EXECUTE) r_taken <= branch_taken_i;
            if (pc_write_o) r_instret <= r_instret + 32'd1;
        end
    end
    assign state_o   = r_state;
    assign illegal_o = r_illegal;
    assign timeout_o = r_timeout;
    assign instret_o = r_instret;
endmodule
